memctrl_lfsr_bist: RTL and testbench

//  March-style pseudo-random memory self-test engine. Consumes a 16-bit LFSR pattern stream and owns the

---
 rtl/memctrl_bist_pkg.sv | 16 +
 rtl/memctrl_bist_fail_log.sv | 50 +++++
 rtl/memctrl_lfsr_bist.sv | 147 ++++++++++++++
 tb/tb_memctrl_lfsr_bist.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memctrl_bist_pkg.sv
// rtl/memctrl_bist_pkg.sv - shared state encoding and pattern constants for the LFSR memory BIST
package memctrl_bist_pkg;

  localparam int              PAT_W     = 16;
  localparam logic [PAT_W-1:0] LFSR_SEED = 16'h0001;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    GAP   = 3'd2,
    READ  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } bist_state_e;

endpackage

// File: rtl/memctrl_bist_fail_log.sv
// rtl/memctrl_bist_fail_log.sv - failing-address register file with saturating count and sticky overflow
module memctrl_bist_fail_log #(
  parameter int ADDR_W   = 8,
  parameter int MAX_FAIL = 4,
  localparam int CNT_W   = $clog2(MAX_FAIL + 1),
  localparam int IDX_W   = (MAX_FAIL > 1) ? $clog2(MAX_FAIL) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_clr,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [CNT_W-1:0]  o_fail_cnt,
  output logic              o_fail_ovf
);

  logic [ADDR_W-1:0] r_log [MAX_FAIL];
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;
  logic              w_full;

  assign w_full = (r_cnt >= CNT_W'(MAX_FAIL));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
      for (int i = 0; i < MAX_FAIL; i++) r_log[i] <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
      for (int i = 0; i < MAX_FAIL; i++) r_log[i] <= '0;
    end else if (i_wr) begin
      if (!w_full) begin
        r_log[r_cnt[IDX_W-1:0]] <= i_addr;
        r_cnt                   <= r_cnt + 1'b1;
      end else begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Slots at or beyond the fill level read as zero so stale entries never leak out.
  assign o_rd_addr  = (CNT_W'(i_rd_idx) < r_cnt) ? r_log[i_rd_idx] : '0;
  assign o_fail_cnt = r_cnt;
  assign o_fail_ovf = r_ovf;

endmodule

// File: rtl/memctrl_lfsr_bist.sv
// rtl/memctrl_lfsr_bist.sv - write/reseed/read-compare LFSR memory self-test with repair log
module memctrl_lfsr_bist
  import memctrl_bist_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int MAX_FAIL = 4,
  localparam int CNT_W   = $clog2(MAX_FAIL + 1),
  localparam int IDX_W   = (MAX_FAIL > 1) ? $clog2(MAX_FAIL) : 1,
  localparam int DC_W    = $clog2(RD_LAT + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              lfsr_en,
  input  logic [PAT_W-1:0]  lfsr_out,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PAT_W-1:0]  mem_wdata,
  input  logic [PAT_W-1:0]  mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail_valid,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              fail_ovf,
  input  logic [IDX_W-1:0]  spare_idx,
  output logic [ADDR_W-1:0] spare_addr
);

  bist_state_e       r_state, w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DC_W-1:0]   r_drain_cnt;
  logic              r_pass;

  logic [RD_LAT-1:0] r_dl_vld;
  logic [ADDR_W-1:0] r_dl_addr [RD_LAT];
  logic [PAT_W-1:0]  r_dl_data [RD_LAT];

  logic w_clr, w_write, w_read, w_done, w_busy;
  logic w_miscmp;
  logic [CNT_W-1:0] w_log_cnt;
  logic             w_log_ovf;

  always_comb begin
    w_next_state = r_state;
    w_clr        = 1'b0;
    w_write      = 1'b0;
    w_read       = 1'b0;
    w_done       = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          w_clr        = 1'b1;
          w_next_state = WRITE;
        end
      end
      WRITE: begin
        w_write = 1'b1;
        if (&r_addr) w_next_state = GAP;
      end
      GAP:   w_next_state = READ;
      READ: begin
        w_read = 1'b1;
        if (&r_addr) w_next_state = DRAIN;
      end
      DRAIN: if (r_drain_cnt == DC_W'(RD_LAT - 1)) w_next_state = DONE;
      DONE: begin
        w_done       = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_drain_cnt <= '0;
      r_pass      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      // The counter wraps from all-ones to zero on its own between the passes.
      if (w_clr)                 r_addr <= '0;
      else if (w_write || w_read) r_addr <= r_addr + 1'b1;
      r_drain_cnt <= (r_state == DRAIN) ? r_drain_cnt + 1'b1 : '0;
      if (w_clr)       r_pass <= 1'b0;
      else if (w_done) r_pass <= (w_log_cnt == '0) && !w_log_ovf;
    end
  end

  // Expected data and address travel alongside the read so they line up with mem_rdata.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dl_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_dl_addr[i] <= '0;
        r_dl_data[i] <= '0;
      end
    end else begin
      r_dl_vld[0]  <= w_read;
      r_dl_addr[0] <= r_addr;
      r_dl_data[0] <= lfsr_out;
      for (int i = 1; i < RD_LAT; i++) begin
        r_dl_vld[i]  <= r_dl_vld[i-1];
        r_dl_addr[i] <= r_dl_addr[i-1];
        r_dl_data[i] <= r_dl_data[i-1];
      end
    end
  end

  assign w_miscmp = r_dl_vld[RD_LAT-1] && (r_dl_data[RD_LAT-1] != mem_rdata);

  memctrl_bist_fail_log #(
    .ADDR_W   (ADDR_W),
    .MAX_FAIL (MAX_FAIL)
  ) u_fail_log (
    .clk        (clk),
    .rstn       (rstn),
    .i_clr      (w_clr),
    .i_wr       (w_miscmp),
    .i_addr     (r_dl_addr[RD_LAT-1]),
    .i_rd_idx   (spare_idx),
    .o_rd_addr  (spare_addr),
    .o_fail_cnt (w_log_cnt),
    .o_fail_ovf (w_log_ovf)
  );

  assign lfsr_en    = w_write || w_read;
  assign mem_cs     = w_write || w_read;
  assign mem_we     = w_write;
  assign mem_addr   = r_addr;
  assign mem_wdata  = w_write ? lfsr_out : '0;
  assign busy       = w_busy;
  assign done       = w_done;
  assign pass       = r_pass;
  assign fail_valid = w_miscmp;
  assign fail_addr  = w_miscmp ? r_dl_addr[RD_LAT-1] : '0;
  assign fail_cnt   = w_log_cnt;
  assign fail_ovf   = w_log_ovf;

endmodule

// File: tb/tb_memctrl_lfsr_bist.sv
// tb/tb_memctrl_lfsr_bist.sv - scoreboard bench: LFSR and SRAM models around two BIST instances (RD_LAT 1 and 3)
module tb_memctrl_lfsr_bist;

  localparam int AW = 4;
  localparam int CW = 3;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          start     [2];
  logic [IW-1:0] spare_idx [2];
  wire           lfsr_en   [2];
  wire  [15:0]   lfsr_out  [2];
  wire           mem_cs    [2];
  wire           mem_we    [2];
  wire  [AW-1:0] mem_addr  [2];
  wire  [15:0]   mem_wdata [2];
  wire  [15:0]   mem_rdata [2];
  wire           busy      [2];
  wire           done      [2];
  wire           pass      [2];
  wire           fail_valid[2];
  wire  [AW-1:0] fail_addr [2];
  wire  [CW-1:0] fail_cnt  [2];
  wire           fail_ovf  [2];
  wire  [AW-1:0] spare_addr[2];

  logic [15:0] f_and [2][16];
  logic [15:0] f_xor [2][16];

  int n_cmp = 0;
  int n_bad = 0;

  int exp_fail_addr[$], exp_fail_cyc[$], exp_wr_data[$];
  int obs_fail_addr[$], obs_fail_cyc[$], obs_wr_addr[$], obs_wr_data[$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int RL = (g == 0) ? 1 : 3;
    logic [15:0] r_lfsr;
    logic [15:0] mem   [16];
    logic [15:0] rpipe [RL];

    always @(posedge clk or negedge rstn) begin
      if (!rstn)            r_lfsr <= 16'h0001;
      else if (!lfsr_en[g]) r_lfsr <= 16'h0001;
      else                  r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
    assign lfsr_out[g] = r_lfsr;

    always @(posedge clk) begin
      if (mem_cs[g] && mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
      rpipe[0] <= (mem[mem_addr[g]] & f_and[g][mem_addr[g]]) ^ f_xor[g][mem_addr[g]];
      for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata[g] = rpipe[RL-1];

    memctrl_lfsr_bist #(.ADDR_W(AW), .RD_LAT(RL), .MAX_FAIL(4)) u_dut (
      .clk        (clk),
      .rstn       (rstn),
      .start      (start[g]),
      .lfsr_en    (lfsr_en[g]),
      .lfsr_out   (lfsr_out[g]),
      .mem_cs     (mem_cs[g]),
      .mem_we     (mem_we[g]),
      .mem_addr   (mem_addr[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_rdata  (mem_rdata[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .pass       (pass[g]),
      .fail_valid (fail_valid[g]),
      .fail_addr  (fail_addr[g]),
      .fail_cnt   (fail_cnt[g]),
      .fail_ovf   (fail_ovf[g]),
      .spare_idx  (spare_idx[g]),
      .spare_addr (spare_addr[g])
    );
  end

  function automatic logic [15:0] exp_pat(input int k);
    logic [15:0] s;
    s = 16'h0001;
    for (int i = 0; i < k; i++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    return s;
  endfunction

  task automatic clear_faults();
    for (int g = 0; g < 2; g++)
      for (int a = 0; a < 16; a++) begin
        f_and[g][a] = 16'hFFFF;
        f_xor[g][a] = 16'h0000;
      end
  endtask

  // Runs one test on instance g, recording writes and fail pulses by cycle (start sampled at edge 0).
  task automatic run_bist(input int g, input int pulse_a, input int pulse_b, output int done_cyc);
    obs_fail_addr.delete(); obs_fail_cyc.delete();
    obs_wr_addr.delete();   obs_wr_data.delete();
    done_cyc = -1;
    @(negedge clk); start[g] = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c < 200; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      start[g] = (c == pulse_a) || (c == pulse_b);
      if (mem_cs[g] && mem_we[g]) begin
        obs_wr_addr.push_back(int'(mem_addr[g]));
        obs_wr_data.push_back(int'(mem_wdata[g]));
      end
      if (fail_valid[g]) begin
        obs_fail_addr.push_back(int'(fail_addr[g]));
        obs_fail_cyc.push_back(c);
      end
      if (done[g]) begin
        done_cyc = c;
        break;
      end
    end
    start[g] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int g = 0; g < 2; g++) begin
      n_cmp++;
      if ({lfsr_en[g], mem_cs[g], mem_we[g], mem_addr[g], mem_wdata[g], busy[g], done[g], pass[g],
           fail_valid[g], fail_addr[g], fail_cnt[g], fail_ovf[g], spare_addr[g]} !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs dut%0d: busy=%b pass=%b cs=%b wdata=%h cnt=%0d (all must be 0)",
                 g, busy[g], pass[g], mem_cs[g], mem_wdata[g], fail_cnt[g]);
      end
    end
  endtask

  task automatic test_fault_free();
    int dc;
    clear_faults();
    for (int k = 0; k < 16; k++) exp_wr_data.push_back(int'(exp_pat(k)));
    run_bist(0, 0, 0, dc);
    n_cmp++;
    if (dc !== 35) begin n_bad++; $display("FAIL clean_done_cycle: got %0d want 35", dc); end
    n_cmp++;
    if (obs_wr_addr.size() !== 16) begin n_bad++; $display("FAIL clean_write_count: got %0d want 16", obs_wr_addr.size()); end
    for (int i = 0; obs_wr_addr.size() > 0 && exp_wr_data.size() > 0; i++) begin
      int a, d, e;
      a = obs_wr_addr.pop_front(); d = obs_wr_data.pop_front(); e = exp_wr_data.pop_front();
      n_cmp++;
      if (a !== i || d !== e) begin
        n_bad++;
        $display("FAIL clean_write_%0d: got addr %0d data %h want addr %0d data %h", i, a, d, i, e);
      end
    end
    exp_wr_data.delete();
    n_cmp++;
    if (obs_fail_addr.size() !== 0) begin n_bad++; $display("FAIL clean_no_fail_pulse: got %0d pulses want 0", obs_fail_addr.size()); end
    n_cmp++;
    if ({pass[0], fail_cnt[0], fail_ovf[0], busy[0]} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL clean_result: got pass=%b cnt=%0d ovf=%b busy=%b want 1 0 0 0", pass[0], fail_cnt[0], fail_ovf[0], busy[0]);
    end
  endtask

  task automatic check_fail_events(input string tag);
    n_cmp++;
    if (obs_fail_addr.size() !== exp_fail_addr.size()) begin
      n_bad++;
      $display("FAIL %s_pulse_count: got %0d want %0d", tag, obs_fail_addr.size(), exp_fail_addr.size());
    end
    while (obs_fail_addr.size() > 0 && exp_fail_addr.size() > 0) begin
      int oa, oc, ea, ec;
      oa = obs_fail_addr.pop_front(); oc = obs_fail_cyc.pop_front();
      ea = exp_fail_addr.pop_front(); ec = exp_fail_cyc.pop_front();
      n_cmp++;
      if (oa !== ea || oc !== ec) begin
        n_bad++;
        $display("FAIL %s_fail_event: got addr %0d cycle %0d want addr %0d cycle %0d", tag, oa, oc, ea, ec);
      end
    end
    exp_fail_addr.delete(); exp_fail_cyc.delete();
  endtask

  task automatic test_stuck_at0();
    int dc;
    clear_faults();
    f_and[0][0] = 16'hFFFE;
    exp_fail_addr.push_back(0); exp_fail_cyc.push_back(18 + 1);
    run_bist(0, 0, 0, dc);
    check_fail_events("sa0");
    spare_idx[0] = 2'd0; #1;
    n_cmp++;
    if ({fail_cnt[0], spare_addr[0], pass[0], dc} !== {3'd1, 4'd0, 1'b0, 35}) begin
      n_bad++;
      $display("FAIL sa0_result: got cnt=%0d spare0=%0d pass=%b done=%0d want 1 0 0 35", fail_cnt[0], spare_addr[0], pass[0], dc);
    end
  endtask

  task automatic test_overflow();
    int dc;
    int faddr [5] = '{1, 3, 5, 7, 9};
    clear_faults();
    foreach (faddr[i]) begin
      f_xor[0][faddr[i]] = 16'h0100;
      exp_fail_addr.push_back(faddr[i]); exp_fail_cyc.push_back(18 + faddr[i] + 1);
    end
    run_bist(0, 0, 0, dc);
    check_fail_events("ovf");
    n_cmp++;
    if ({fail_cnt[0], fail_ovf[0], pass[0]} !== {3'd4, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL ovf_result: got cnt=%0d ovf=%b pass=%b want 4 1 0", fail_cnt[0], fail_ovf[0], pass[0]);
    end
    for (int i = 0; i < 4; i++) begin
      spare_idx[0] = IW'(i); #1;
      n_cmp++;
      if (int'(spare_addr[0]) !== faddr[i]) begin
        n_bad++;
        $display("FAIL ovf_spare_%0d: got %0d want %0d", i, spare_addr[0], faddr[i]);
      end
    end
    spare_idx[0] = 2'd0;
  endtask

  task automatic test_async_reset();
    int dc;
    clear_faults();
    f_and[0][0] = 16'hFFFE;
    @(negedge clk); start[0] = 1'b1;
    @(posedge clk); #1; start[0] = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    n_cmp++;
    if ({fail_cnt[0], busy[0], mem_we[0]} !== {3'd1, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL arst_pre_state: got cnt=%0d busy=%b we=%b want 1 1 0", fail_cnt[0], busy[0], mem_we[0]);
    end
    #1 rstn = 1'b0;
    #1;
    n_cmp++;
    if ({lfsr_en[0], mem_cs[0], mem_we[0], mem_addr[0], mem_wdata[0], busy[0], done[0], pass[0],
         fail_valid[0], fail_addr[0], fail_cnt[0], fail_ovf[0], spare_addr[0]} !== '0) begin
      n_bad++;
      $display("FAIL arst_outputs: got lfsr_en=%b cs=%b busy=%b addr=%0d cnt=%0d (all must be 0)",
               lfsr_en[0], mem_cs[0], busy[0], mem_addr[0], fail_cnt[0]);
    end
    @(negedge clk); rstn = 1'b1;
    clear_faults();
    run_bist(0, 0, 0, dc);
    n_cmp++;
    if ({pass[0], fail_cnt[0], dc} !== {1'b1, 3'd0, 35}) begin
      n_bad++;
      $display("FAIL arst_rerun: got pass=%b cnt=%0d done=%0d want 1 0 35", pass[0], fail_cnt[0], dc);
    end
  endtask

  task automatic test_start_ignored();
    int dc;
    clear_faults();
    run_bist(0, 5, 34, dc);
    n_cmp++;
    if ({dc, obs_wr_addr.size(), obs_fail_addr.size()} !== {35, 16, 0}) begin
      n_bad++;
      $display("FAIL restart_timing: got done=%0d writes=%0d fails=%0d want 35 16 0", dc, obs_wr_addr.size(), obs_fail_addr.size());
    end
    n_cmp++;
    if ({pass[0], fail_cnt[0], fail_ovf[0], busy[0]} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL restart_result: got pass=%b cnt=%0d ovf=%b busy=%b want 1 0 0 0", pass[0], fail_cnt[0], fail_ovf[0], busy[0]);
    end
  endtask

  task automatic test_rd_lat3();
    int dc;
    clear_faults();
    f_and[1][0] = 16'hFFFE;
    exp_fail_addr.push_back(0); exp_fail_cyc.push_back(18 + 3);
    run_bist(1, 0, 0, dc);
    check_fail_events("lat3");
    n_cmp++;
    if ({dc, fail_cnt[1], pass[1]} !== {37, 3'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL lat3_result: got done=%0d cnt=%0d pass=%b want 37 1 0", dc, fail_cnt[1], pass[1]);
    end
  endtask

  initial begin
    start[0] = 1'b0; start[1] = 1'b0;
    spare_idx[0] = '0; spare_idx[1] = '0;
    clear_faults();
    #12;
    test_reset();
    @(negedge clk); rstn = 1'b1;
    test_fault_free();
    test_stuck_at0();
    test_overflow();
    test_async_reset();
    test_start_ignored();
    test_rd_lat3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
